spram: RTL and testbench
========================

SPRAM -- requirements
Module: spram

Interface
REQ-001 The block SHALL have parameter DATA, default 8, meaning data word width in bits.
REQ-002 The block SHALL have parameter ADDR, default 10, meaning address width in bits, with depth 2^ADDR words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low (0 = reset, sampled on rising clk).
REQ-005 The block SHALL have port we, input, 1 bit: write enable; 1 = write din to addr, 0 = read addr.
REQ-006 The block SHALL have port addr, input, ADDR bits: word address for both read and write.
REQ-007 The block SHALL have port din, input, DATA bits: write data.
REQ-008 The block SHALL have port dout, output, DATA bits: registered read data.
REQ-009 The block SHALL have port busy, output, 1 bit: 1 while the post-reset clear sweep runs; the port MAY be left unconnected.

Function
REQ-010 Storage SHALL be 2^ADDR words of DATA bits, addressed by the full addr; no address range checking, since every addr value is valid.
REQ-011 Write: on a rising clk with rst=1, busy=0 and we=1, mem[addr] SHALL take din; the new value SHALL be readable on the next access.
REQ-012 Read: on a rising clk with rst=1, busy=0 and we=0, dout SHALL take mem[addr]; read latency is exactly 1 cycle.
REQ-013 Read-during-write: on a write cycle, dout SHALL take the old content of mem[addr] (read-first), giving the pre-write value 1 cycle later.
REQ-014 dout SHALL hold its last value whenever no read or write cycle occurs; it SHALL change only on a rising clk.
REQ-015 Clear sweep: the block SHALL have a clear counter of ADDR bits; while busy=1 it SHALL write 0 to mem[counter] each cycle and then increment.
REQ-016 The sweep SHALL start on the first rising clk with rst=1 after reset and SHALL take exactly 2^ADDR cycles; busy SHALL then drop to 0.
REQ-017 While busy=1, we, addr and din SHALL be ignored and dout SHALL stay 0.
REQ-018 The sweep counter SHALL end on the all-ones address; busy SHALL fall on the cycle after that address is cleared, and the counter SHALL NOT wrap into a second sweep.
REQ-019 The control SHALL be a two-state machine, states CLEAR (busy=1) and IDLE (busy=0): reset leads to CLEAR; CLEAR goes to IDLE after the last address; IDLE stays in IDLE until reset.

Reset
REQ-020 While rst=0 at a rising clk, dout SHALL be set to 0, the counter SHALL be set to 0, and the state SHALL be CLEAR with busy=1.
REQ-021 While rst=0, no memory word SHALL be written.
REQ-022 Memory content SHALL be undefined at power-up and SHALL be all-zero once busy first falls.
REQ-023 Reset asserted mid-operation, including mid-sweep, SHALL abort the current access or sweep and restart the full sweep at address 0 after rst returns to 1.
REQ-024 A write or read sampled in the same cycle as rst=0 SHALL have no effect.

Verification (DATA=8, ADDR=4)
REQ-025 Bench SHALL apply rst=0 for 2 cycles and then rst=1 -> dout=0 and busy=1 for exactly 16 cycles, then busy=0, then reading addr 0..15 gives dout=0x00 each one cycle after the address is presented.
REQ-026 Bench SHALL write 0xA5 to addr 3 and then read addr 3 -> dout=0xA5 on the cycle after the read edge.
REQ-027 Bench SHALL write 0x11 to addr 7 and then write 0x22 to addr 7 -> dout=0x11 after the second write (read-first), and a following read of addr 7 gives 0x22.
REQ-028 Bench SHALL write 0x3C to addr 15, read addr 15 and then read addr 0 -> dout sequence 0x3C, 0x00, confirming no aliasing at the top address.
REQ-029 Bench SHALL drive we=1, addr=5, din=0xFF during the sweep -> after busy falls, a read of addr 5 gives 0x00.
REQ-030 Bench SHALL write 0x5A to addr 2, pulse rst=0 in the middle of a later sweep or access, and then wait for busy to fall -> a read of addr 2 gives 0x00.

Source files
------------

// File: rtl/spram_if.sv
// -----------------------------------------------------------------------------
// spram_if
// Bus bundle for the single-port RAM. The master drives the access request
// and the slave (the RAM) returns registered read data and a busy flag.
//
// Signals:
//    we   - write enable (1 = write din to addr, 0 = read addr)
//    addr - word address for both reads and writes
//    din  - write data
//    dout - registered read data, valid one cycle after the access edge
//    busy - high while the post-reset clear sweep is running
// -----------------------------------------------------------------------------
interface spram_if #(
   parameter int DATA = 8,
   parameter int ADDR = 10
);

   logic            we;
   logic [ADDR-1:0] addr;
   logic [DATA-1:0] din;
   logic [DATA-1:0] dout;
   logic            busy;

   // Requesting side: issues accesses and observes the results
   modport master (
      output we,
      output addr,
      output din,
      input  dout,
      input  busy
   );

   // RAM side: accepts accesses and returns data plus sweep status
   modport slave (
      input  we,
      input  addr,
      input  din,
      output dout,
      output busy
   );

endinterface

// File: rtl/spram.sv
// -----------------------------------------------------------------------------
// spram
// Single-port synchronous RAM of 2**ADDR words by DATA bits, read-first on
// write cycles, with a hardware clear sweep after every reset. Contents are
// undefined at power-up; the sweep zeroes every word one address per cycle,
// and accesses are ignored until it finishes.
//
// Ports:
//    clk - single clock, all state changes on its rising edge
//    rst - synchronous active-low reset
//    bus - spram_if slave modport (we, addr, din in; dout, busy out)
// -----------------------------------------------------------------------------
module spram #(
   parameter int DATA = 8,
   parameter int ADDR = 10
) (
   input  logic   clk,
   input  logic   rst,
   spram_if.slave bus
);

   typedef enum logic {
      CLEAR,
      IDLE
   } stateT;

   localparam logic [ADDR-1:0] LastAddr = '1;

   stateT           r_state;
   stateT           w_nextState;
   logic [ADDR-1:0] r_clrCnt;
   logic [DATA-1:0] r_dout;
   logic [DATA-1:0] r_mem [2**ADDR];

   logic            w_memWe;
   logic [ADDR-1:0] w_memAddr;
   logic [DATA-1:0] w_memData;

   // State register: reset always returns to CLEAR so that the full sweep
   // restarts from address 0, even if reset lands in the middle of one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= CLEAR;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and memory-port selection. During CLEAR the sweep counter
   // owns the write port and the bus is ignored; during IDLE the bus owns it.
   // The rst term keeps reset cycles from writing any word.
   always_comb begin
      w_nextState = r_state;
      w_memWe     = 1'b0;
      w_memAddr   = bus.addr;
      w_memData   = bus.din;
      case (r_state)
         CLEAR: begin
            w_memWe   = rst;
            w_memAddr = r_clrCnt;
            w_memData = '0;
            if (r_clrCnt == LastAddr) begin
               w_nextState = IDLE;
            end
         end
         IDLE: begin
            w_memWe = rst & bus.we;
         end
         default: begin
            w_nextState = CLEAR;
         end
      endcase
   end

   // Sweep counter: parks on the all-ones address once it gets there so a
   // finished sweep can never wrap around into a second one.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_clrCnt <= '0;
      end else if (r_state == CLEAR && r_clrCnt != LastAddr) begin
         r_clrCnt <= r_clrCnt + 1'b1;
      end
   end

   // Read data register. Every IDLE cycle is either a read or a write, and
   // both return the word as it stood before this edge (read-first). While
   // sweeping, dout keeps the zero it was given by reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_dout <= '0;
      end else if (r_state == IDLE) begin
         r_dout <= r_mem[bus.addr];
      end
   end

   // Storage array, kept free of reset so it maps onto RAM primitives.
   always_ff @(posedge clk) begin
      if (w_memWe) begin
         r_mem[w_memAddr] <= w_memData;
      end
   end

   assign bus.dout = r_dout;
   assign bus.busy = (r_state == CLEAR);

endmodule

// File: tb/tb_spram.sv
// -----------------------------------------------------------------------------
// tb_spram
// Directed scoreboard bench for spram (DATA=8, ADDR=4). The stimulus side
// pushes the expected dout/busy for each checked access into a queue; a
// separate monitor pops and compares one cycle after that access is sampled.
// -----------------------------------------------------------------------------
module tb_spram;

   typedef struct {
      logic [7:0] dout;
      logic       busy;
      string      name;
   } ExpT;

   logic clk = 1'b0;
   logic rst = 1'b0;
   bit   chk = 1'b0;
   bit   chkD = 1'b0;
   int   checks = 0;
   int   errors = 0;
   ExpT  expQ[$];

   spram_if #(.DATA(8), .ADDR(4)) bus ();

   spram #(.DATA(8), .ADDR(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Marks the cycle whose result the monitor should examine
   always @(posedge clk) begin
      chkD <= chk;
   end

   // Drive one cycle of inputs at the falling edge; optionally queue the
   // dout/busy values expected after the following rising edge.
   task automatic applyStimulus(input logic rstV, input logic weV,
                                input logic [3:0] addrV, input logic [7:0] dinV,
                                input bit doChk, input logic [7:0] expDout,
                                input logic expBusy, input string nm);
      ExpT e;
      @(negedge clk);
      rst      = rstV;
      bus.we   = weV;
      bus.addr = addrV;
      bus.din  = dinV;
      chk      = doChk;
      if (doChk) begin
         e.dout = expDout;
         e.busy = expBusy;
         e.name = nm;
         expQ.push_back(e);
      end
   endtask

   // Compare current DUT outputs against one scoreboard entry
   task automatic checkOutput(input ExpT e);
      checks++;
      if (bus.dout !== e.dout) begin
         errors++;
         $display("[TB] FAIL %s dout: got 0x%02h, expected 0x%02h", e.name, bus.dout, e.dout);
      end
      checks++;
      if (bus.busy !== e.busy) begin
         errors++;
         $display("[TB] FAIL %s busy: got %b, expected %b", e.name, bus.busy, e.busy);
      end
   endtask

   // Monitor: pops the scoreboard whenever a checked access has completed
   always @(negedge clk) begin
      if (chkD) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
         end else begin
            checkOutput(expQ.pop_front());
         end
      end
   end

   // Full sweep after rst rises: busy stays high until the 16th edge
   task automatic runSweep(input string tag);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b1, 1'b1, 4'd5, 8'hFF, 1'b1, 8'h00, (i < 15),
                       $sformatf("%s_sweep%0d", tag, i));
      end
   endtask

   initial begin
      bus.we   = 1'b0;
      bus.addr = '0;
      bus.din  = '0;

      // Reset held for two cycles
      applyStimulus(1'b0, 1'b1, 4'd1, 8'h99, 1'b1, 8'h00, 1'b1, "reset0");
      applyStimulus(1'b0, 1'b0, 4'd1, 8'h00, 1'b1, 8'h00, 1'b1, "reset1");

      // Clear sweep, with write attempts to addr 5 that must be ignored
      runSweep("init");

      // Every word reads back as zero
      for (int a = 0; a < 16; a++) begin
         applyStimulus(1'b1, 1'b0, a[3:0], 8'h00, 1'b1, 8'h00, 1'b0,
                       $sformatf("zero_rd%0d", a));
      end

      // Write then read addr 3
      applyStimulus(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, 8'h00, 1'b0, "wr3");
      applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'hA5, 1'b0, "rd3");

      // Read-first on back-to-back writes to addr 7
      applyStimulus(1'b1, 1'b1, 4'd7, 8'h11, 1'b1, 8'h00, 1'b0, "wr7a");
      applyStimulus(1'b1, 1'b1, 4'd7, 8'h22, 1'b1, 8'h11, 1'b0, "wr7b");
      applyStimulus(1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 8'h22, 1'b0, "rd7");

      // Top address does not alias onto address 0
      applyStimulus(1'b1, 1'b1, 4'd15, 8'h3C, 1'b1, 8'h00, 1'b0, "wr15");
      applyStimulus(1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 8'h3C, 1'b0, "rd15");
      applyStimulus(1'b1, 1'b0, 4'd0,  8'h00, 1'b1, 8'h00, 1'b0, "rd0");

      // Idle cycle with a read holds the previously written data path intact
      applyStimulus(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, 8'hA5, 1'b0, "rd3again");

      // Write addr 2, then reset, partial sweep, reset again mid-sweep
      applyStimulus(1'b1, 1'b1, 4'd2, 8'h5A, 1'b1, 8'h00, 1'b0, "wr2");
      applyStimulus(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, 8'h5A, 1'b0, "rd2");
      applyStimulus(1'b0, 1'b1, 4'd2, 8'h77, 1'b1, 8'h00, 1'b1, "rst_b");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, 4'd2, 8'h66, 1'b1, 8'h00, 1'b1,
                       $sformatf("part_sweep%0d", i));
      end
      applyStimulus(1'b0, 1'b0, 4'd2, 8'h00, 1'b1, 8'h00, 1'b1, "rst_mid");
      runSweep("re");

      // Everything written before the reset is gone
      applyStimulus(1'b1, 1'b0, 4'd2,  8'h00, 1'b1, 8'h00, 1'b0, "rd2_clr");
      applyStimulus(1'b1, 1'b0, 4'd3,  8'h00, 1'b1, 8'h00, 1'b0, "rd3_clr");
      applyStimulus(1'b1, 1'b0, 4'd7,  8'h00, 1'b1, 8'h00, 1'b0, "rd7_clr");
      applyStimulus(1'b1, 1'b0, 4'd15, 8'h00, 1'b1, 8'h00, 1'b0, "rd15_clr");

      // Drain the scoreboard
      applyStimulus(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 8'h00, 1'b0, "drain");
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d entries left, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
